// File: rtl/motor_switch_pkg.sv
// Shared opcodes, FSM encoding and frame-length helpers for motor_switch_ctrl.
package motor_switch_pkg;

    localparam logic [1:0] OP_DIR      = 2'b00;
    localparam logic [1:0] OP_SERVO_EN = 2'b01;
    localparam logic [1:0] OP_MOTOR_EN = 2'b10;
    localparam logic [1:0] OP_RSVD     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Opcode + payload, plus one trailing parity bit when parity is built in.
    function automatic int frame_len(input int data_w, input bit parity);
        return data_w + 2 + (parity ? 1 : 0);
    endfunction

endpackage

// File: rtl/deadtime_gate.sv
// Per-motor dead-time counter: a direction flip holds dt_active high for DEADTIME cycles.
module deadtime_gate #(
    parameter int DEADTIME = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic flip,
    output logic dt_active
);

    localparam int CNT_W = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;

    logic [CNT_W-1:0] cnt;

    // A flip during an active countdown restarts the full window.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (flip) begin
            cnt <= CNT_W'(DEADTIME);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign dt_active = (cnt != '0);

endmodule

// File: rtl/motor_switch_ctrl.sv
// Motor/servo PWM router configured over a cs/sda framed link.
// Define MOTOR_SWITCH_PARITY_EN to require a trailing even-parity bit on every frame.
module motor_switch_ctrl
    import motor_switch_pkg::*;
#(
    parameter int NUM_MOTORS = 6,
    parameter int NUM_SERVOS = 6,
    parameter int DEADTIME   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cs,
    input  logic                    sda,
    input  logic [NUM_MOTORS-1:0]   motors_in,
    input  logic                    servo_in,
    output logic [2*NUM_MOTORS-1:0] motors_out,
    output logic [NUM_SERVOS-1:0]   servos_out,
    output logic                    cfg_valid,
    output logic                    frame_err,
    output logic [NUM_MOTORS-1:0]   dt_active
);

    localparam int DATA_W  = max_int(NUM_MOTORS, NUM_SERVOS);
    localparam int FRAME_W = DATA_W + 2;
`ifdef MOTOR_SWITCH_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif
    localparam int EXP_LEN = frame_len(DATA_W, PARITY);
    localparam int MAX_CNT = EXP_LEN + 1;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    state_t state, state_next;

    logic [EXP_LEN-1:0]    frame;
    logic [CNT_W-1:0]      bitcnt;
    logic [1:0]            opcode;
    logic [DATA_W-1:0]     payload;
    logic                  len_ok;
    logic                  parity_ok;
    logic                  frame_ok;

    logic [NUM_MOTORS-1:0] dir_reg;
    logic [NUM_MOTORS-1:0] motor_en_reg;
    logic [NUM_SERVOS-1:0] servo_en_reg;
    logic [NUM_MOTORS-1:0] dir_flip;

    assign opcode  = frame[1:0];
    assign payload = frame[FRAME_W-1:2];
    assign len_ok  = (bitcnt == CNT_W'(EXP_LEN));

`ifdef MOTOR_SWITCH_PARITY_EN
    assign parity_ok = ~^frame;
`else
    assign parity_ok = 1'b1;
`endif

    assign frame_ok = len_ok && (opcode != OP_RSVD) && parity_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // CHECK always returns to IDLE; a cs=1 seen in CHECK is deliberately ignored.
    always_comb begin
        state_next = state;
        cfg_valid  = 1'b0;
        frame_err  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!cs) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                state_next = ST_IDLE;
                if (frame_ok) cfg_valid = 1'b1;
                else          frame_err = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bits land LSB first; bitcnt stops one past the expected length to flag overlong frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame  <= '0;
            bitcnt <= '0;
        end else if (state == ST_IDLE && cs) begin
            frame  <= EXP_LEN'(sda);
            bitcnt <= CNT_W'(1);
        end else if (state == ST_SHIFT && cs) begin
            if (bitcnt < CNT_W'(EXP_LEN)) begin
                frame <= frame | (EXP_LEN'(sda) << bitcnt);
            end
            if (bitcnt != CNT_W'(MAX_CNT)) begin
                bitcnt <= bitcnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_reg      <= '0;
            motor_en_reg <= '0;
            servo_en_reg <= '0;
        end else if (cfg_valid) begin
            case (opcode)
                OP_DIR:      dir_reg      <= payload[NUM_MOTORS-1:0];
                OP_SERVO_EN: servo_en_reg <= payload[NUM_SERVOS-1:0];
                OP_MOTOR_EN: motor_en_reg <= payload[NUM_MOTORS-1:0];
                default:     ;
            endcase
        end
    end

    assign dir_flip = (cfg_valid && opcode == OP_DIR) ?
                      (payload[NUM_MOTORS-1:0] ^ dir_reg) : '0;

    for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_motor
        deadtime_gate #(
            .DEADTIME (DEADTIME)
        ) u_deadtime_gate (
            .clk       (clk),
            .reset     (reset),
            .flip      (dir_flip[i]),
            .dt_active (dt_active[i])
        );

        assign motors_out[2*i]   = motors_in[i] & motor_en_reg[i] & ~dir_reg[i] & ~dt_active[i];
        assign motors_out[2*i+1] = motors_in[i] & motor_en_reg[i] &  dir_reg[i] & ~dt_active[i];
    end

    assign servos_out = {NUM_SERVOS{servo_in}} & servo_en_reg;

endmodule

// File: tb/tb_motor_switch_ctrl.sv
// Randomized bench for motor_switch_ctrl against a frame-level reference model.
module tb_motor_switch_ctrl;

    localparam int NM      = 6;
    localparam int NS      = 6;
    localparam int DT      = 4;
    localparam int DATA_W  = 6;
    localparam int FRAME_W = DATA_W + 2;
`ifdef MOTOR_SWITCH_PARITY_EN
    localparam int EXP_LEN = FRAME_W + 1;
    localparam bit PAR     = 1'b1;
`else
    localparam int EXP_LEN = FRAME_W;
    localparam bit PAR     = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            cs;
    logic            sda;
    logic [NM-1:0]   motors_in;
    logic            servo_in;
    logic [2*NM-1:0] motors_out;
    logic [NS-1:0]   servos_out;
    logic            cfg_valid;
    logic            frame_err;
    logic [NM-1:0]   dt_active;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit hold_pwm = 1'b0;

    // reference model: configuration words and the cycle of each motor's last reversal
    logic [NM-1:0] m_dir;
    logic [NM-1:0] m_men;
    logic [NS-1:0] m_sen;
    int            last_flip[NM];
    logic [1:0]    exp_q[$];

    motor_switch_ctrl #(
        .NUM_MOTORS (NM),
        .NUM_SERVOS (NS),
        .DEADTIME   (DT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .sda        (sda),
        .motors_in  (motors_in),
        .servo_in   (servo_in),
        .motors_out (motors_out),
        .servos_out (servos_out),
        .cfg_valid  (cfg_valid),
        .frame_err  (frame_err),
        .dt_active  (dt_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_dir = '0;
        m_men = '0;
        m_sen = '0;
        for (int i = 0; i < NM; i++) last_flip[i] = -100;
    endtask

    task automatic check_all(input logic exp_cfg, input logic exp_err);
        logic [NM-1:0]   dt_e;
        logic [2*NM-1:0] mo_e;
        logic [NS-1:0]   so_e;
        for (int i = 0; i < NM; i++) begin
            dt_e[i]     = (cyc - last_flip[i]) < DT;
            mo_e[2*i]   = motors_in[i] & m_men[i] & ~m_dir[i] & ~dt_e[i];
            mo_e[2*i+1] = motors_in[i] & m_men[i] &  m_dir[i] & ~dt_e[i];
        end
        for (int j = 0; j < NS; j++) so_e[j] = servo_in & m_sen[j];
        check("dt_active",  32'(dt_active),  32'(dt_e));
        check("motors_out", 32'(motors_out), 32'(mo_e));
        check("servos_out", 32'(servos_out), 32'(so_e));
        check("cfg_valid",  32'(cfg_valid),  32'(exp_cfg));
        check("frame_err",  32'(frame_err),  32'(exp_err));
    endtask

    task automatic tick(input logic exp_cfg, input logic exp_err);
        if (!hold_pwm) begin
            motors_in = NM'($urandom);
            servo_in  = 1'($urandom);
        end
        @(negedge clk);
        check_all(exp_cfg, exp_err);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] make_frame(input logic [1:0] op, input logic [DATA_W-1:0] pay,
                                               input bit good_par);
        logic [31:0] b;
        b = (32'(pay) << 2) | 32'(op);
        if (PAR) b[FRAME_W] = (^b[FRAME_W-1:0]) ^ (good_par ? 1'b0 : 1'b1);
        return b;
    endfunction

    task automatic send_frame(input logic [31:0] bits, input int len);
        logic        ok;
        logic        p;
        logic [31:0] pay;
        logic [1:0]  e;
        p = 1'b0;
        for (int i = 0; i < len; i++) p ^= bits[i];
        ok = (len == EXP_LEN) && (bits[1:0] != 2'b11) && (!PAR || !p);
        for (int i = 0; i < len; i++) begin
            cs  = 1'b1;
            sda = bits[i];
            tick(1'b0, 1'b0);
        end
        cs  = 1'b0;
        sda = 1'b0;
        exp_q.push_back({ok, !ok});
        tick(1'b0, 1'b0);
        e = exp_q.pop_front();
        tick(e[1], e[0]);
        if (ok) begin
            pay = bits >> 2;
            case (bits[1:0])
                2'b00: begin
                    for (int i = 0; i < NM; i++)
                        if (pay[i] != m_dir[i]) last_flip[i] = cyc;
                    m_dir = pay[NM-1:0];
                end
                2'b01: m_sen = pay[NS-1:0];
                2'b10: m_men = pay[NM-1:0];
                default: ;
            endcase
        end
    endtask

    initial begin
        reset     = 1'b1;
        cs        = 1'b0;
        sda       = 1'b0;
        motors_in = 6'h3F;
        servo_in  = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_motors_out", 32'(motors_out), 32'h000);
        check("rst_servos_out", 32'(servos_out), 32'h00);
        check("rst_cfg_valid",  32'(cfg_valid),  32'h0);
        check("rst_frame_err",  32'(frame_err),  32'h0);
        check("rst_dt_active",  32'(dt_active),  32'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) tick(1'b0, 1'b0);

        // enable all motors, then reverse motors 0 and 2
        send_frame(make_frame(2'b10, 6'h3F, 1'b1), EXP_LEN);
        hold_pwm  = 1'b1;
        motors_in = 6'h3F;
        servo_in  = 1'b1;
        send_frame(make_frame(2'b00, 6'h05, 1'b1), EXP_LEN);
        @(negedge clk);
        check("dir_dt_start", 32'(dt_active),  32'h05);
        check("dir_dt_pins",  32'(motors_out), 32'h544);
        @(posedge clk);
        #1;
        repeat (3) tick(1'b0, 1'b0);
        @(negedge clk);
        check("dir_after_dt", 32'(motors_out), 32'h566);
        check("dir_dt_clear", 32'(dt_active),  32'h00);
        @(posedge clk);
        #1;
        hold_pwm = 1'b0;

        send_frame(make_frame(2'b01, 6'h21, 1'b1), EXP_LEN);
        repeat (6) tick(1'b0, 1'b0);

        // length errors, saturated overlong and reserved opcode
        send_frame(make_frame(2'b10, 6'h00, 1'b1), EXP_LEN - 1);
        send_frame(make_frame(2'b10, 6'h00, 1'b1), EXP_LEN + 1);
        send_frame(make_frame(2'b00, 6'h3A, 1'b1), EXP_LEN + 3);
        send_frame(make_frame(2'b11, 6'h3F, 1'b1), EXP_LEN);

        // back-to-back reversals of motor 1
        send_frame(make_frame(2'b00, m_dir ^ 6'h02, 1'b1), EXP_LEN);
        send_frame(make_frame(2'b00, m_dir ^ 6'h02, 1'b1), EXP_LEN);
        repeat (5) tick(1'b0, 1'b0);

`ifdef MOTOR_SWITCH_PARITY_EN
        send_frame(make_frame(2'b01, 6'h12, 1'b0), EXP_LEN);
        send_frame(make_frame(2'b01, 6'h12, 1'b1), EXP_LEN);
`endif

        // reset mid-frame, then a fresh frame starting while cs stays high
        for (int i = 0; i < 4; i++) begin
            cs  = 1'b1;
            sda = 1'($urandom);
            tick(1'b0, 1'b0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        tick(1'b0, 1'b0);
        hold_pwm  = 1'b1;
        motors_in = 6'h3F;
        servo_in  = 1'b1;
        @(negedge clk);
        check("midrst_motors_out", 32'(motors_out), 32'h000);
        check("midrst_servos_out", 32'(servos_out), 32'h00);
        @(posedge clk);
        #1;
        hold_pwm = 1'b0;
        reset    = 1'b0;
        send_frame(make_frame(2'b10, 6'h2B, 1'b1), EXP_LEN);

        for (int n = 0; n < 40; n++) begin
            logic [1:0]  op;
            logic [5:0]  pay;
            int          len;
            int          r;
            bit          gp;
            op  = 2'($urandom_range(0, 3));
            pay = 6'($urandom);
            r   = $urandom_range(0, 5);
            len = (r == 0) ? EXP_LEN - 1 : (r == 1) ? EXP_LEN + 1 : (r == 2) ? EXP_LEN + 3 : EXP_LEN;
            gp  = ($urandom_range(0, 3) != 0);
            send_frame(make_frame(op, pay, gp), len);
            repeat ($urandom_range(0, 3)) tick(1'b0, 1'b0);
        end
        repeat (6) tick(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
